// File: rtl/wavelet_pkg.sv
// Shared defaults, the Mexican-hat kernel and FSM state codes for the
// wavelet FIR.
package wavelet_pkg;

    localparam int BITS_PER_ELEM_DEF  = 8;
    localparam int SUM_TRUNCATION_DEF = 8;
    localparam int MAX_BITS_DEF       = 16;
    localparam int FIR_NUM_ELEM       = 9;

    // Coefficient k lives in bits [8k+7:8k]: -10 -36 -59 28 124 28 -59 -36 -10
    localparam logic [71:0] FILTER_VAL_DEF = 72'hf6dcc51c7c1cc5dcf6;

    typedef logic [1:0] wavelet_state_t;
    localparam wavelet_state_t IDLE = 2'd0;
    localparam wavelet_state_t MAC  = 2'd1;
    localparam wavelet_state_t DONE = 2'd2;

endpackage

// File: rtl/wavelet_fir_if.sv
// Sample window, start request and result bus of one wavelet FIR instance.
interface wavelet_fir_if
    import wavelet_pkg::*;
#(
    parameter int BITS_PER_ELEM  = BITS_PER_ELEM_DEF,
    parameter int NUM_ELEM       = FIR_NUM_ELEM,
    parameter int SUM_TRUNCATION = SUM_TRUNCATION_DEF
);
    logic [BITS_PER_ELEM*NUM_ELEM-1:0] taps;
    logic                              i_start_calc;
    logic [SUM_TRUNCATION-1:0]         o_wavelet;
    logic                              o_valid;

    modport master (output taps, output i_start_calc, input o_wavelet, input o_valid);
    modport slave  (input taps, input i_start_calc, output o_wavelet, output o_valid);
endinterface

// File: rtl/wavelet_fir_mac.sv
// Signed coefficient times unsigned sample, accumulated into a wide signed
// register with synchronous clear and enable.
module wavelet_fir_mac
    import wavelet_pkg::*;
#(
    parameter int BITS_PER_ELEM = BITS_PER_ELEM_DEF,
    parameter int ACC_W         = MAX_BITS_DEF + 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_clear,
    input  logic                            i_en,
    input  logic signed [BITS_PER_ELEM-1:0] i_coef,
    input  logic        [BITS_PER_ELEM-1:0] i_tap,
    output logic signed [ACC_W-1:0]         o_acc
);
    logic signed [2*BITS_PER_ELEM:0] w_prod;
    logic signed [ACC_W-1:0]         r_acc;

    // Zero-extend the sample so it multiplies as a non-negative signed value.
    assign w_prod = i_coef * $signed({1'b0, i_tap});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + ACC_W'(w_prod);
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/wavelet_fir.sv
// Sequential 9-tap wavelet FIR: one MAC reused across the window, then an
// arithmetic scale; WAVELET_FIR_SATURATION_EN selects clamping over wrapping.
module wavelet_fir
    import wavelet_pkg::*;
#(
    parameter int                                BITS_PER_ELEM  = BITS_PER_ELEM_DEF,
    parameter int                                SUM_TRUNCATION = SUM_TRUNCATION_DEF,
    parameter int                                NUM_ELEM       = FIR_NUM_ELEM,
    parameter logic [BITS_PER_ELEM*NUM_ELEM-1:0] FILTER_VAL     = FILTER_VAL_DEF,
    parameter int                                MAX_BITS       = MAX_BITS_DEF,
    parameter int                                BASE_NUM_ELEM  = FIR_NUM_ELEM
) (
    input  logic          clk,
    input  logic          rst,
    wavelet_fir_if.slave  bus
);
    localparam int ACC_W = MAX_BITS + 4;
    localparam int SHIFT = MAX_BITS - SUM_TRUNCATION;
    localparam int IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

    generate
        if (BASE_NUM_ELEM != NUM_ELEM) begin : g_len_check
            $error("wavelet_fir: BASE_NUM_ELEM must equal NUM_ELEM");
        end
    endgenerate

    function automatic logic [SUM_TRUNCATION-1:0] scale_out(input logic signed [ACC_W-1:0] acc);
`ifdef WAVELET_FIR_SATURATION_EN
        localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (SUM_TRUNCATION - 1)) - 1);
        localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(1 << (SUM_TRUNCATION - 1));
        logic signed [ACC_W-1:0] sh;
        sh = acc >>> SHIFT;
        if (sh > SAT_MAX)      return SUM_TRUNCATION'(SAT_MAX);
        else if (sh < SAT_MIN) return SUM_TRUNCATION'(SAT_MIN);
        else                   return SUM_TRUNCATION'(sh);
`else
        return SUM_TRUNCATION'(acc >>> SHIFT);
`endif
    endfunction

    wavelet_state_t                    r_state;
    logic [IDX_W-1:0]                  r_idx;
    logic [BITS_PER_ELEM*NUM_ELEM-1:0] r_taps;
    logic [SUM_TRUNCATION-1:0]         r_wavelet;
    logic                              r_valid;

    logic                              w_accept;
    logic signed [BITS_PER_ELEM-1:0]   w_coef;
    logic        [BITS_PER_ELEM-1:0]   w_tap;
    logic signed [ACC_W-1:0]           w_acc;

    assign w_accept = (r_state == IDLE) && bus.i_start_calc;
    assign w_coef   = $signed(FILTER_VAL[r_idx*BITS_PER_ELEM +: BITS_PER_ELEM]);
    assign w_tap    = r_taps[r_idx*BITS_PER_ELEM +: BITS_PER_ELEM];

    // Window is captured once so the caller may keep shifting samples in.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_taps <= bus.taps;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_wavelet <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.i_start_calc) begin
                        r_idx   <= '0;
                        r_state <= MAC;
                    end
                end
                MAC: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_wavelet <= scale_out(w_acc);
                    r_valid   <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    wavelet_fir_mac #(
        .BITS_PER_ELEM (BITS_PER_ELEM),
        .ACC_W         (ACC_W)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_accept),
        .i_en    (r_state == MAC),
        .i_coef  (w_coef),
        .i_tap   (w_tap),
        .o_acc   (w_acc)
    );

    assign bus.o_wavelet = r_wavelet;
    assign bus.o_valid   = r_valid;

endmodule

// File: tb/tb_wavelet_fir.sv
// Directed bench for wavelet_fir: latency, held result, busy-start rejection,
// mid-calculation reset and both output mapping modes.
module tb_wavelet_fir;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wavelet_fir_if bus ();

    wavelet_fir dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef WAVELET_FIR_SATURATION_EN
    localparam logic [7:0] EXP_MID3  = 8'h7F;
    localparam logic [7:0] EXP_OUTER = 8'h80;
`else
    localparam logic [7:0] EXP_MID3  = 8'hB3;
    localparam logic [7:0] EXP_OUTER = 8'h2E;
`endif

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] taps_of(input logic [8:0] mask, input logic [7:0] v);
        logic [71:0] t;
        t = '0;
        for (int k = 0; k < 9; k++) begin
            if (mask[k]) t[8*k +: 8] = v;
        end
        return t;
    endfunction

    // Start one calculation; optionally raise a second start after edge 'extra'.
    task automatic run_calc(input string tag, input logic [71:0] t, input int extra,
                            input logic [7:0] exp);
        int lat;
        int pulses;
        logic [7:0] val;
        lat = 0;
        pulses = 0;
        val = 8'h00;
        @(negedge clk);
        bus.taps = t;
        bus.i_start_calc = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start_calc = 1'b0;
        bus.taps = ~t;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_valid) begin
                pulses++;
                if (lat == 0) begin
                    lat = k;
                    val = bus.o_wavelet;
                end
            end
            bus.i_start_calc = (k == extra);
        end
        chk({tag, "_lat"}, lat, 10);
        chk({tag, "_pulses"}, pulses, 1);
        chk({tag, "_val"}, {24'd0, val}, {24'd0, exp});
        chk({tag, "_hold"}, {24'd0, bus.o_wavelet}, {24'd0, exp});
    endtask

    initial begin
        int pulses;
        rst = 1'b0;
        bus.taps = '0;
        bus.i_start_calc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wavelet", {24'd0, bus.o_wavelet}, 32'h0);
        chk("rst_valid", {31'd0, bus.o_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        run_calc("zero",   taps_of(9'h000, 8'd0),   0, 8'h00);
        run_calc("all255", taps_of(9'h1FF, 8'd255), 0, 8'hE2);
        run_calc("centre", taps_of(9'h010, 8'd255), 0, 8'h7B);
        run_calc("mid3",   taps_of(9'h038, 8'd255), 0, EXP_MID3);
        run_calc("outer",  taps_of(9'h1C7, 8'd255), 0, EXP_OUTER);
        run_calc("all1",   taps_of(9'h1FF, 8'd1),   0, 8'hFF);
        run_calc("busy",   taps_of(9'h010, 8'd255), 3, 8'h7B);

        // Abort a calculation that would otherwise yield 0xE2.
        @(negedge clk);
        bus.taps = taps_of(9'h1FF, 8'd255);
        bus.i_start_calc = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start_calc = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("abort_wavelet", {24'd0, bus.o_wavelet}, 32'h0);
        chk("abort_valid", {31'd0, bus.o_valid}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_valid) pulses++;
        end
        chk("abort_no_pulse", pulses, 0);
        chk("abort_held", {24'd0, bus.o_wavelet}, 32'h0);

        run_calc("after_rst", taps_of(9'h1FF, 8'd255), 0, 8'hE2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
